// File: rtl/inst_pkg.sv
// Purpose: ISA constants, field positions, format classes and FSM states for the instruction encoder.
// Latency: n/a (declarations and pure combinational helpers only).
// Backpressure: n/a.
package inst_pkg;

    localparam logic [2:0] OP_0 = 3'd0;
    localparam logic [2:0] OP_1 = 3'd1;
    localparam logic [2:0] OP_2 = 3'd2;
    localparam logic [2:0] OP_3 = 3'd3;
    localparam logic [2:0] OP_4 = 3'd4;
    localparam logic [2:0] OP_5 = 3'd5;
    localparam logic [2:0] OP_6 = 3'd6;
    localparam logic [2:0] OP_7 = 3'd7;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 29;
    localparam int R0_HI  = 28;
    localparam int R0_LO  = 24;
    localparam int R1_HI  = 23;
    localparam int R1_LO  = 19;
    localparam int R2_HI  = 18;
    localparam int R2_LO  = 14;

    // Width of the address/immediate field carried by each format class.
    localparam int ADDR_W_A = 16;
    localparam int ADDR_W_B = 15;
    localparam int ADDR_W_C = 14;

    // A: op0-1 (r0 + 16-bit addr), B: op2-3 (r0, r1 + 15-bit), C: op4-7 (r0, r1, r2 + 14-bit).
    typedef enum logic [1:0] {
        FMT_A = 2'd0,
        FMT_B = 2'd1,
        FMT_C = 2'd2
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic fmt_t fmt_of(input logic [2:0] op);
        fmt_t f;
        case (op)
            OP_0, OP_1:             f = FMT_A;
            OP_2, OP_3:             f = FMT_B;
            OP_4, OP_5, OP_6, OP_7: f = FMT_C;
            default:                f = FMT_C;
        endcase
        return f;
    endfunction

    // Unused bits are always driven 0 so the written word never carries X.
    function automatic logic [31:0] encode(input logic [2:0]  op,
                                           input logic [4:0]  r0,
                                           input logic [4:0]  r1,
                                           input logic [4:0]  r2,
                                           input logic [15:0] addr);
        logic [31:0] w;
        w = '0;
        w[OPC_HI:OPC_LO] = op;
        w[R0_HI:R0_LO]   = r0;
        case (fmt_of(op))
            FMT_A: w[ADDR_W_A-1:0] = addr;
            FMT_B: begin
                w[R1_HI:R1_LO]   = r1;
                w[ADDR_W_B-1:0]  = addr[ADDR_W_B-1:0];
            end
            default: begin
                w[R1_HI:R1_LO]   = r1;
                w[R2_HI:R2_LO]   = r2;
                w[ADDR_W_C-1:0]  = addr[ADDR_W_C-1:0];
            end
        endcase
        return w;
    endfunction

    // True when addr has bits set above what the opcode's format can carry.
    function automatic logic range_viol(input logic [2:0] op, input logic [15:0] addr);
        logic v;
        case (fmt_of(op))
            FMT_A:   v = 1'b0;
            FMT_B:   v = addr[15];
            default: v = |addr[15:14];
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: generic single-clock FIFO with full/empty flags; ports clk, rst_n, push/push_dat, pop/pop_dat, full, empty.
// Latency: pushed word visible on pop_dat the cycle after the push (no write-through bypass).
// Backpressure: push ignored while full, pop ignored while empty; caller gates on the flags.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Purpose: encode instruction field sets into 32-bit words, buffer them and write them to imem from BASE_ADDR.
// Latency: word accepted in cycle N appears on imem_* in cycle N+1 at the earliest; 1 word/cycle sustained.
// Backpressure: in_ready drops while the buffer is full; imem_addr/imem_wdata hold while imem_ready is low.
// Ports: start/busy/done session control; in_* field-set handshake; imem_* write port; word_count, range_err status.
// Build option: define INST_ENC_RANGE_CHECK_EN to drop out-of-range field sets and flag them on range_err.
module inst_encoder
    import inst_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IMEM_AW    = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_opcode,
    input  logic [4:0]         in_r0,
    input  logic [4:0]         in_r1,
    input  logic [4:0]         in_r2,
    input  logic [15:0]        in_addr,
    input  logic               in_last,
    output logic               imem_we,
    input  logic               imem_ready,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               busy,
    output logic               done,
    output logic [IMEM_AW:0]   word_count,
    output logic               range_err
);
    localparam logic [IMEM_AW-1:0] BASE   = BASE_ADDR[IMEM_AW-1:0];
    localparam logic [IMEM_AW:0]   WC_MAX = {1'b1, {IMEM_AW{1'b0}}};

    state_t      state_q;
    state_t      state_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;
    logic [31:0] enc_dat;
    logic        accept;
    logic        push;
    logic        wr_done;

    assign enc_dat = encode(in_opcode, in_r0, in_r1, in_r2, in_addr);
    assign accept  = in_valid && in_ready;
    assign wr_done = imem_we && imem_ready;

`ifdef INST_ENC_RANGE_CHECK_EN
    logic viol;
    assign viol = range_viol(in_opcode, in_addr);
    // A violating set still completes its handshake (and its in_last) but is never buffered.
    assign push = accept && !viol;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            range_err <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            range_err <= 1'b0;
        end else if (accept && viol) begin
            range_err <= 1'b1;
        end
    end
`else
    assign push      = accept;
    assign range_err = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (enc_dat),
        .pop      (wr_done),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (accept && in_last) state_d = ST_DRAIN;
            // An empty buffer means the last write has already completed.
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        imem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                // Full blocks acceptance even when a pop happens this cycle.
                in_ready = !fifo_full;
                imem_we  = !fifo_empty;
                busy     = 1'b1;
            end
            ST_DRAIN: begin
                imem_we  = !fifo_empty;
                busy     = 1'b1;
            end
            ST_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    // Gate the head so stale or uninitialised buffer contents never reach the port.
    assign imem_wdata = imem_we ? fifo_head : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_addr  <= BASE;
            word_count <= '0;
        end else if (state_q == ST_IDLE && start) begin
            imem_addr  <= BASE;
            word_count <= '0;
        end else if (wr_done) begin
            imem_addr <= imem_addr + 1'b1;
            if (word_count != WC_MAX) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule
